board_reset_seq: RTL

Parametrised board-level reset and startup sequencer, sitting between the clock wizard and the functional top. It replaces a single fixed safe-start register. It synchronises the asynchronous push-button and PLL-locked inputs, debounces the button, and waits for a stable lock. It then releases N_CH active-high downstream resets one at a time, in ascending order, with a programmable gap between releases. Button press, lock loss or a software request aborts the sequence and re-asserts every reset.

---
 rtl/board_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 75 +++++++
 rtl/board_reset_seq.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/board_pkg.sv
// -----------------------------------------------------------------------------
// board_pkg
// Shared definitions for the board reset / startup sequencer:
//   - seq_state_t : sequencer FSM states (HOLD, RELEASE, RUN)
//   - DEF_*       : default parameter values for the board build
//   - cnt_width() : width of a counter that must hold 0..max_val inclusive
// -----------------------------------------------------------------------------
package board_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,   // every channel held in reset, filtering lock
        RELEASE = 2'd1,   // releasing channels one at a time
        RUN     = 2'd2    // all channels released
    } seq_state_t;

    localparam int DEF_N_CH            = 3;
    localparam int DEF_DEBOUNCE_CYCLES = 65000;
    localparam int DEF_LOCK_FILTER     = 256;
    localparam int DEF_STAGE_GAP       = 16;

    // Counters saturate at their terminal value, so they must be able to
    // represent max_val itself, not just max_val-1.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser followed by a consecutive-sample debounce filter for a
// slow asynchronous board input (push-button, jumper, switch).
//
// The filtered level only changes after the synchronised input has disagreed
// with it on DEBOUNCE_CYCLES consecutive edges; any agreement restarts the
// count.
//
// Ports:
//   clk    in   sampling clock
//   rst_n  in   synchronous active-low reset (clears synchroniser, level, count)
//   raw    in   asynchronous input
//   db     out  debounced level. It is the value the internal level register
//               takes at the coming edge, so a consumer registering on the
//               same edge sees a change on the edge the filter accepts it.
//               Driven only from flops; there is no path from raw.
// -----------------------------------------------------------------------------
module btn_debounce
    import board_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic db
);

    localparam int            CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    (* ASYNC_REG = "TRUE" *) logic sync1;
    (* ASYNC_REG = "TRUE" *) logic sync2;

    logic          db_q;
    logic          db_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_next;

    // NOTE: state flops use non-blocking assignments so every register
    // samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            db_q  <= 1'b0;
            cnt   <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            db_q  <= db_next;
            cnt   <= cnt_next;
        end
    end

    // NOTE: every output of this block is given a default first, so no path
    // through it leaves a variable unassigned and no latch is inferred.
    always_comb begin
        db_next  = db_q;
        cnt_next = '0;
        if (sync2 != db_q) begin
            // This edge is one more disagreement; accept the new level when
            // it completes the required run, otherwise keep counting.
            if (cnt >= CNT_LAST) begin
                db_next = sync2;
            end else begin
                cnt_next = cnt + 1'b1;
            end
        end
    end

    assign db = db_next;

endmodule

// File: rtl/board_reset_seq.sv
// -----------------------------------------------------------------------------
// board_reset_seq
// Board-level reset and startup sequencer between the clock wizard and the
// functional top. Waits for a stable PLL lock with the button released, then
// releases N_CH active-high channel resets in ascending order, STAGE_GAP
// cycles apart. Lock loss, a debounced button press or a soft-reset request
// aborts the sequence and re-asserts every channel.
//
// Ports:
//   clk         in   sequencer clock (65 MHz domain)
//   rst_n       in   synchronous active-low reset
//   btn_raw     in   asynchronous push-button, active-high
//   pll_locked  in   asynchronous clock-wizard lock flag
//   sw_rst      in   synchronous single-cycle soft-reset request
//   rst_out     out  active-high reset per channel, bit 0 released first
//   ready       out  high once every channel is released
//   fault       out  sticky: lock was lost while in RUN; cleared by rst_n only
// -----------------------------------------------------------------------------
module board_reset_seq
    import board_pkg::*;
#(
    parameter int N_CH            = DEF_N_CH,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOCK_FILTER     = DEF_LOCK_FILTER,
    parameter int STAGE_GAP       = DEF_STAGE_GAP
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_raw,
    input  logic            pll_locked,
    input  logic            sw_rst,
    output logic [N_CH-1:0] rst_out,
    output logic            ready,
    output logic            fault
);

    localparam int LW = cnt_width(LOCK_FILTER);
    localparam int GW = cnt_width(STAGE_GAP);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [LW-1:0] LOCK_LAST = LW'(LOCK_FILTER - 1);
    localparam logic [LW-1:0] LOCK_MAX  = LW'(LOCK_FILTER);
    localparam logic [GW-1:0] GAP_LAST  = GW'(STAGE_GAP - 1);
    localparam logic [GW-1:0] GAP_MAX   = GW'(STAGE_GAP);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_CH - 1);

    // -------------------------------------------------------------------------
    // Input conditioning
    // -------------------------------------------------------------------------
    (* ASYNC_REG = "TRUE" *) logic lock_sync1;
    (* ASYNC_REG = "TRUE" *) logic locked_s;

    logic btn_db;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_raw),
        .db    (btn_db)
    );

    // -------------------------------------------------------------------------
    // Sequencer state
    // -------------------------------------------------------------------------
    seq_state_t      state;
    seq_state_t      state_next;
    logic [LW-1:0]   lock_cnt;
    logic [LW-1:0]   lock_cnt_next;
    logic [GW-1:0]   gap_cnt;
    logic [GW-1:0]   gap_cnt_next;
    logic [IW-1:0]   idx;            // highest channel already released
    logic [IW-1:0]   idx_next;
    logic [N_CH-1:0] rst_out_next;
    logic            ready_next;
    logic            fault_next;
    logic            abort_req;

    // Any one of these tears the sequence down once it has started.
    assign abort_req = !locked_s || btn_db || sw_rst;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lock_sync1 <= 1'b0;
            locked_s   <= 1'b0;
            state      <= HOLD;
            lock_cnt   <= '0;
            gap_cnt    <= '0;
            idx        <= '0;
            rst_out    <= '1;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            lock_sync1 <= pll_locked;
            locked_s   <= lock_sync1;
            state      <= state_next;
            lock_cnt   <= lock_cnt_next;
            gap_cnt    <= gap_cnt_next;
            idx        <= idx_next;
            rst_out    <= rst_out_next;
            ready      <= ready_next;
            fault      <= fault_next;
        end
    end

    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        gap_cnt_next  = gap_cnt;
        idx_next      = idx;
        rst_out_next  = rst_out;
        ready_next    = ready;
        fault_next    = fault;

        if (state != HOLD && abort_req) begin
            // Abort wins over any release due on this same edge.
            if (state == RUN && !locked_s) begin
                fault_next = 1'b1;
            end
            state_next    = HOLD;
            rst_out_next  = '1;
            ready_next    = 1'b0;
            lock_cnt_next = '0;
            gap_cnt_next  = '0;
            idx_next      = '0;
        end else begin
            unique case (state)
                HOLD: begin
                    rst_out_next = '1;
                    ready_next   = 1'b0;
                    gap_cnt_next = '0;
                    idx_next     = '0;
                    if (!locked_s) begin
                        lock_cnt_next = '0;
                    end else if (lock_cnt >= LOCK_LAST && !btn_db && !sw_rst) begin
                        // The count may have saturated while the button was
                        // still held, hence >= rather than ==.
                        state_next      = RELEASE;
                        rst_out_next[0] = 1'b0;
                        lock_cnt_next   = '0;
                    end else if (lock_cnt != LOCK_MAX) begin
                        lock_cnt_next = lock_cnt + 1'b1;
                    end
                end

                RELEASE: begin
                    if (idx == IDX_LAST) begin
                        // Last channel went out on the previous edge.
                        state_next = RUN;
                        ready_next = 1'b1;
                    end else if (gap_cnt >= GAP_LAST) begin
                        idx_next     = idx + 1'b1;
                        gap_cnt_next = '0;
                        for (int i = 0; i < N_CH; i++) begin
                            if (i == int'(idx_next)) begin
                                rst_out_next[i] = 1'b0;
                            end
                        end
                    end else if (gap_cnt != GAP_MAX) begin
                        gap_cnt_next = gap_cnt + 1'b1;
                    end
                end

                RUN: begin
                    // Outputs hold until an abort.
                end

                default: begin
                    state_next    = HOLD;
                    rst_out_next  = '1;
                    ready_next    = 1'b0;
                    lock_cnt_next = '0;
                    gap_cnt_next  = '0;
                    idx_next      = '0;
                end
            endcase
        end
    end

endmodule
